// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared constants and state type for the programmable sequence detector
package seq_detect_pkg;
  localparam logic MODE_OVERLAP = 1'b1;
  localparam logic MODE_NONOVL = 1'b0;
  typedef enum logic {ST_FILL, ST_ARMED} state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with synchronous clear and registered saturation flag
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             sat
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic sat_q;
  assign cnt_d = clr ? WIDTH'(inc) : (inc && !sat_q) ? cnt_q + 1'b1 : cnt_q;
  // count register; clear wins over hold but still counts a simultaneous event
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= &cnt_d;
    end
  assign cnt = cnt_q;
  assign sat = sat_q;
endmodule

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial bit-sequence detector with overlap modes and match counter
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W       = 4,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1011,
  parameter logic             DEFAULT_OVL = MODE_OVERLAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             match,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  logic [PAT_W-1:0] pat_q, hist_q, hist_sh, hist_d;
  logic [FW-1:0] fill_q, fill_inc, fill_d;
  logic ovl_q, match_q, accept, hit;
  state_e st_q;
  assign accept = in_valid & ~cfg_we;
  assign hist_sh = {hist_q[PAT_W-2:0], in_bit};
  assign fill_inc = (fill_q == FULL) ? FULL : fill_q + 1'b1;
  assign hit = accept && (hist_sh == pat_q) && (fill_inc == FULL);
  assign hist_d = cfg_we ? '0 : accept ? hist_sh : hist_q;
  assign fill_d = cfg_we ? '0 : !accept ? fill_q : (hit && ovl_q == MODE_NONOVL) ? '0 : fill_inc;
  // config, history, fill-derived FSM and registered match pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pat_q   <= DEFAULT_PAT;
      ovl_q   <= DEFAULT_OVL;
      hist_q  <= '0;
      fill_q  <= '0;
      st_q    <= ST_FILL;
      match_q <= 1'b0;
    end else begin
      if (cfg_we) begin
        pat_q <= cfg_pattern;
        ovl_q <= cfg_overlap;
      end
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      st_q    <= (fill_d == FULL) ? ST_ARMED : ST_FILL;
      match_q <= hit;
    end
  sat_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(hit),
    .clr(cnt_clr),
    .cnt(match_cnt),
    .sat(cnt_sat)
  );
  assign match = match_q;
  assign armed = (st_q == ST_ARMED);
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: table, directed and random checks of seq_detect_prog against a queue model
module tb_seq_detect_prog;
  logic clk = 1'b0;
  logic rst, in_valid, in_bit, cfg_we, cfg_overlap, cnt_clr;
  logic [3:0] cfg_pattern;
  logic match, armed, cnt_sat, match2, armed2, cnt_sat2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  int total = 0, bad = 0;

  seq_detect_prog dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .match(match), .armed(armed), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );
  seq_detect_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .match(match2), .armed(armed2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );

  always #5 clk = ~clk;

  bit q[$];
  logic [3:0] m_pat;
  bit m_ovl, m_match;
  int m_cnt, m_cnt2;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pat = 4'b1011;
    m_ovl = 1'b1;
    m_match = 1'b0;
    m_cnt = 0;
    m_cnt2 = 0;
  endtask

  // bits since last restart kept in a queue; a hit is the last four equal to the pattern
  task automatic model_step(input bit v, input bit b, input bit we, input logic [3:0] pat, input bit ovl, input bit clr);
    bit hit = 1'b0;
    logic [3:0] w = 4'b0;
    if (we) begin
      q.delete();
      m_pat = pat;
      m_ovl = ovl;
    end else if (v) begin
      q.push_back(b);
      if (q.size() >= 4) begin
        for (int i = q.size() - 4; i < q.size(); i++) w = {w[2:0], q[i]};
        hit = (w == m_pat);
      end
      if (hit && !m_ovl) q.delete();
      else if (q.size() > 4) void'(q.pop_front());
    end
    if (clr) begin
      m_cnt = int'(hit);
      m_cnt2 = int'(hit);
    end else if (hit) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    m_match = hit;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " match"}, int'(match), int'(m_match));
    chk({tag, " armed"}, int'(armed), int'(q.size() >= 4));
    chk({tag, " cnt"}, int'(match_cnt), m_cnt);
    chk({tag, " sat"}, int'(cnt_sat), int'(m_cnt == 255));
    chk({tag, " match2"}, int'(match2), int'(m_match));
    chk({tag, " cnt2"}, int'(match_cnt2), m_cnt2);
    chk({tag, " sat2"}, int'(cnt_sat2), int'(m_cnt2 == 3));
  endtask

  task automatic step(input bit v, input bit b, input bit we, input logic [3:0] pat, input bit ovl, input bit clr, input string tag);
    in_valid = v;
    in_bit = b;
    cfg_we = we;
    cfg_pattern = pat;
    cfg_overlap = ovl;
    cnt_clr = clr;
    @(posedge clk);
    model_step(v, b, we, pat, ovl, clr);
    #1;
    check_model(tag);
  endtask

  task automatic bit_in(input bit b, input string tag);
    step(1'b1, b, 1'b0, 4'h0, 1'b0, 1'b0, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, tag);
  endtask

  task automatic cfg(input logic [3:0] pat, input bit ovl, input string tag);
    step(1'b0, 1'b0, 1'b1, pat, ovl, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    cnt_clr = 1'b0;
    #1;
    chk({tag, " rst match"}, int'(match), 0);
    chk({tag, " rst armed"}, int'(armed), 0);
    chk({tag, " rst cnt"}, int'(match_cnt), 0);
    chk({tag, " rst sat"}, int'(cnt_sat), 0);
    chk({tag, " rst cnt2"}, int'(match_cnt2), 0);
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  typedef struct {
    bit v, b, we;
    logic [3:0] pat;
    bit ovl, clr, em, ea;
    int ec;
  } vec_t;
  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1, 1, 0, 4'h0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 4'h0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 4'h0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 4'h0, 0, 0, 1, 1, 1};
    tbl[4]  = '{1, 0, 0, 4'h0, 0, 0, 0, 1, 1};
    tbl[5]  = '{1, 1, 0, 4'h0, 0, 0, 0, 1, 1};
    tbl[6]  = '{1, 1, 0, 4'h0, 0, 0, 1, 1, 2};
    tbl[7]  = '{0, 0, 0, 4'h0, 0, 0, 0, 1, 2};
    tbl[8]  = '{0, 0, 1, 4'hB, 0, 1, 0, 0, 0};
    tbl[9]  = '{1, 1, 0, 4'h0, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 0, 0, 4'h0, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 1, 0, 4'h0, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 1, 0, 4'h0, 0, 0, 1, 0, 1};
    tbl[13] = '{1, 0, 0, 4'h0, 0, 0, 0, 0, 1};
    tbl[14] = '{1, 1, 0, 4'h0, 0, 0, 0, 0, 1};
    tbl[15] = '{1, 1, 0, 4'h0, 0, 0, 0, 0, 1};
    tbl[16] = '{0, 0, 0, 4'h0, 0, 0, 0, 0, 1};
    cfg_pattern = 4'h0;
    cfg_overlap = 1'b0;
    in_bit = 1'b0;
    do_reset("init");

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].b, tbl[i].we, tbl[i].pat, tbl[i].ovl, tbl[i].clr, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d exp match", i), int'(match), int'(tbl[i].em));
      chk($sformatf("tbl%0d exp armed", i), int'(armed), int'(tbl[i].ea));
      chk($sformatf("tbl%0d exp cnt", i), int'(match_cnt), tbl[i].ec);
    end

    cfg(4'b1011, 1'b1, "gap cfg");
    bit_in(1'b1, "gap b0");
    bit_in(1'b0, "gap b1");
    for (int i = 0; i < 3; i++) begin
      idle("gap idle");
      chk("gap idle match", int'(match), 0);
    end
    bit_in(1'b1, "gap b2");
    chk("gap early match", int'(match), 0);
    bit_in(1'b1, "gap b3");
    chk("gap hit", int'(match), 1);

    bit_in(1'b1, "pl b0");
    bit_in(1'b0, "pl b1");
    bit_in(1'b1, "pl b2");
    cfg(4'b1111, 1'b1, "pl cfg");
    chk("pl armed after cfg", int'(armed), 0);
    for (int i = 0; i < 5; i++) begin
      bit_in(1'b1, "pl ones");
      chk($sformatf("pl one%0d match", i), int'(match), int'(i >= 3));
    end

    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, "sat clr+hit");
    chk("sat clr+hit cnt", int'(match_cnt), 1);
    chk("sat clr+hit cnt2", int'(match_cnt2), 1);
    for (int i = 0; i < 4; i++) bit_in(1'b1, "sat ones");
    chk("sat cnt", int'(match_cnt), 5);
    chk("sat cnt2", int'(match_cnt2), 3);
    chk("sat flag2", int'(cnt_sat2), 1);
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, "sat clr2");
    chk("sat clr2 cnt2", int'(match_cnt2), 1);
    chk("sat clr2 flag2", int'(cnt_sat2), 0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, "clr only");
    chk("clr only cnt", int'(match_cnt), 0);

    cfg(4'b0110, 1'b1, "rs cfg");
    bit_in(1'b1, "rs b0");
    bit_in(1'b0, "rs b1");
    bit_in(1'b1, "rs b2");
    do_reset("rs");
    bit_in(1'b1, "rs after");
    chk("rs no partial match", int'(match), 0);
    bit_in(1'b0, "rs d1");
    bit_in(1'b1, "rs d2");
    bit_in(1'b1, "rs d3");
    chk("rs default pattern", int'(match), 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset("rnd");
      else step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 39) == 0, 4'($urandom),
                1'($urandom), $urandom_range(0, 29) == 0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
